// File: rtl/feedback_scorer.sv
// Sequential Mastermind scorer: 4-cycle exact scan, 16-cycle colour scan, 1-cycle report.
// Optional loss tracking is enabled by defining SCORER_LOSE_EN.
module feedback_scorer #(
    parameter int unsigned MAX_TURNS = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       start,
    input  logic [2:0] code0,
    input  logic [2:0] code1,
    input  logic [2:0] code2,
    input  logic [2:0] code3,
    input  logic [2:0] guess0,
    input  logic [2:0] guess1,
    input  logic [2:0] guess2,
    input  logic [2:0] guess3,
    output logic       busy,
    output logic       done,
    output logic [2:0] exact,
    output logic [2:0] partial,
    output logic [1:0] peg0,
    output logic [1:0] peg1,
    output logic [1:0] peg2,
    output logic [1:0] peg3,
    output logic       won,
    output logic       lost,
    output logic [3:0] turns_used
);

    if (MAX_TURNS < 1 || MAX_TURNS > 15) begin : g_bad_max_turns
        $error("feedback_scorer: MAX_TURNS must be 1..15");
    end

    typedef enum logic [1:0] {IDLE, EXACT, PARTIAL, REPORT} state_t;

    state_t     state, state_next;
    logic [2:0] code_q  [4];
    logic [2:0] guess_q [4];
    logic [3:0] gu, cu;
    logic [2:0] ecnt, pcnt;
    logic [3:0] idx;
    logic [1:0] pos_i, pos_j;
    logic       accept;
    logic [3:0] turns_next;
    logic [2:0] match_sum;
    logic [1:0] peg_fill [4];
    logic [1:0] peg_q    [4];

    assign accept     = (state == IDLE) && start && !won && !lost && !clear;
    assign busy       = (state != IDLE);
    assign turns_next = (turns_used == 4'd15) ? 4'd15 : turns_used + 4'd1;
    assign match_sum  = ecnt + pcnt;

    // EXACT walks idx[1:0]; PARTIAL walks idx as {i, j}, i outer
    assign pos_i = (state == PARTIAL) ? idx[3:2] : idx[1:0];
    assign pos_j = idx[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept)         state_next = EXACT;
                EXACT:   if (idx == 4'd3)    state_next = PARTIAL;
                PARTIAL: if (idx == 4'd15)   state_next = REPORT;
                REPORT:                      state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            peg_fill[k] = 2'd0;
            if (3'(k) < ecnt)           peg_fill[k] = 2'd2;
            else if (3'(k) < match_sum) peg_fill[k] = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q     <= '{default: '0};
            guess_q    <= '{default: '0};
            gu         <= '0;
            cu         <= '0;
            ecnt       <= '0;
            pcnt       <= '0;
            idx        <= '0;
            done       <= 1'b0;
            exact      <= '0;
            partial    <= '0;
            peg_q      <= '{default: '0};
            won        <= 1'b0;
            turns_used <= '0;
        end else if (clear) begin
            gu         <= '0;
            cu         <= '0;
            ecnt       <= '0;
            pcnt       <= '0;
            idx        <= '0;
            done       <= 1'b0;
            exact      <= '0;
            partial    <= '0;
            peg_q      <= '{default: '0};
            won        <= 1'b0;
            turns_used <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        code_q  <= '{code0, code1, code2, code3};
                        guess_q <= '{guess0, guess1, guess2, guess3};
                        gu      <= '0;
                        cu      <= '0;
                        ecnt    <= '0;
                        pcnt    <= '0;
                        idx     <= '0;
                    end
                end
                EXACT: begin
                    if (guess_q[pos_i] == code_q[pos_i]) begin
                        gu[pos_i] <= 1'b1;
                        cu[pos_i] <= 1'b1;
                        ecnt      <= ecnt + 3'd1;
                    end
                    idx <= (idx == 4'd3) ? 4'd0 : idx + 4'd1;
                end
                PARTIAL: begin
                    if (!gu[pos_i] && !cu[pos_j] && guess_q[pos_i] == code_q[pos_j]) begin
                        gu[pos_i] <= 1'b1;
                        cu[pos_j] <= 1'b1;
                        pcnt      <= pcnt + 3'd1;
                    end
                    idx <= idx + 4'd1;
                end
                REPORT: begin
                    exact      <= ecnt;
                    partial    <= pcnt;
                    peg_q      <= peg_fill;
                    turns_used <= turns_next;
                    if (ecnt == 3'd4) won <= 1'b1;
                    done       <= 1'b1;
                end
            endcase
        end
    end

    assign peg0 = peg_q[0];
    assign peg1 = peg_q[1];
    assign peg2 = peg_q[2];
    assign peg3 = peg_q[3];

`ifdef SCORER_LOSE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lost <= 1'b0;
        end else if (clear) begin
            lost <= 1'b0;
        end else if (state == REPORT && turns_next == 4'(MAX_TURNS) && ecnt != 3'd4) begin
            lost <= 1'b1;
        end
    end
`else
    assign lost = 1'b0;
`endif

endmodule
